fcims: RTL and testbench

Food-cart inventory management slice (FCIMS): for one item line, computes the extended price of a transaction (unit price × quantity) and applies it to the running item count and running total price. Adds stock when `ctrl`=0 and removes stock when `ctrl`=1. It sits between the transaction-entry logic, which supplies current count and total, and the inventory/ledger registers, which capture `new_ct` and `tprice_final`. Outputs are registered, and illegal transactions are rejected and flagged.

---
 rtl/fcims_pkg.sv | 23 ++
 rtl/fcims_if.sv | 26 ++
 rtl/fcims_mul4.sv | 30 +++
 rtl/fcims.sv | 67 ++++++
 tb/tb_fcims.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fcims_pkg.sv
// Shared widths, opcodes and limits for the food-cart inventory slice.
// Also holds the packed record used for the registered transaction result.
package fcims_pkg;

    localparam int PRICE_W = 4;
    localparam int QTY_W   = 4;
    localparam int CT_W    = 4;
    localparam int TOT_W   = 8;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_REMOVE = 1'b1;

    localparam int unsigned CT_MAX  = 15;
    localparam int unsigned TOT_MAX = 255;

    typedef struct packed {
        logic [TOT_W-1:0] fprice;
        logic [CT_W-1:0]  new_ct;
        logic [TOT_W-1:0] tprice_final;
        logic             err;
    } result_t;

endpackage

// File: rtl/fcims_if.sv
// Transaction bus between entry logic (master) and the inventory slice (slave).
// The master drives the operands and reads back the registered results.
interface fcims_if;
    import fcims_pkg::*;

    logic               ctrl;
    logic [PRICE_W-1:0] uprice;
    logic [QTY_W-1:0]   ncel;
    logic [CT_W-1:0]    ct;
    logic [TOT_W-1:0]   tprice_init;
    logic [TOT_W-1:0]   fprice;
    logic [CT_W-1:0]    new_ct;
    logic [TOT_W-1:0]   tprice_final;
    logic               err;

    modport master (
        output ctrl, uprice, ncel, ct, tprice_init,
        input  fprice, new_ct, tprice_final, err
    );

    modport slave (
        input  ctrl, uprice, ncel, ct, tprice_init,
        output fprice, new_ct, tprice_final, err
    );

endinterface

// File: rtl/fcims_mul4.sv
// Unsigned 4x4 -> 8 combinational multiplier built from shifted partial products.
// The product is exact; 15*15 = 225 fits in 8 bits.
module fcims_mul4
    import fcims_pkg::*;
(
    input  logic [PRICE_W-1:0] a,
    input  logic [QTY_W-1:0]   b,
    output logic [TOT_W-1:0]   p
);

    logic [TOT_W-1:0] pp [QTY_W];
    logic [TOT_W-1:0] sum;

    // One partial product per multiplier bit: a shifted into place, gated by b[gi].
    generate
        for (genvar gi = 0; gi < QTY_W; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? (TOT_W'(a) << gi) : '0;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < QTY_W; i++) begin
            sum = sum + pp[i];
        end
    end

    assign p = sum;

endmodule

// File: rtl/fcims.sv
// One item line: extended price, stock in/out update of count and total,
// range checks with reject-and-hold, and a single registered output bank.
module fcims
    import fcims_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    fcims_if.slave  bus
);

    logic [TOT_W-1:0] prod;
    logic [CT_W:0]    ct_sum;
    logic [TOT_W:0]   tot_sum;
    logic [CT_W-1:0]  ct_diff;
    logic [TOT_W-1:0] tot_diff;
    logic             reject_add;
    logic             reject_remove;
    logic             reject;
    result_t          result_next;
    result_t          result_reg;

    fcims_mul4 u_mul4 (
        .a (bus.uprice),
        .b (bus.ncel),
        .p (prod)
    );

    // Widened sums keep the carry so overflow is visible before truncation.
    assign ct_sum   = {1'b0, bus.ct} + {1'b0, bus.ncel};
    assign tot_sum  = {1'b0, bus.tprice_init} + {1'b0, prod};
    assign ct_diff  = bus.ct - bus.ncel;
    assign tot_diff = bus.tprice_init - prod;

    assign reject_add    = (ct_sum > (CT_W+1)'(CT_MAX)) || (tot_sum > (TOT_W+1)'(TOT_MAX));
    assign reject_remove = (bus.ncel > bus.ct) || (prod > bus.tprice_init);
    assign reject        = (bus.ctrl == OP_ADD) ? reject_add : reject_remove;

    always_comb begin
        result_next.fprice       = prod;
        result_next.new_ct       = bus.ct;
        result_next.tprice_final = bus.tprice_init;
        result_next.err          = reject;
        if (!reject) begin
            if (bus.ctrl == OP_ADD) begin
                result_next.new_ct       = ct_sum[CT_W-1:0];
                result_next.tprice_final = tot_sum[TOT_W-1:0];
            end else begin
                result_next.new_ct       = ct_diff;
                result_next.tprice_final = tot_diff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
        end else begin
            result_reg <= result_next;
        end
    end

    assign bus.fprice       = result_reg.fprice;
    assign bus.new_ct       = result_reg.new_ct;
    assign bus.tprice_final = result_reg.tprice_final;
    assign bus.err          = result_reg.err;

endmodule

// File: tb/tb_fcims.sv
// Self-checking bench for fcims: directed cases, async reset behaviour and
// randomized transactions compared against an arithmetic reference model.
module tb_fcims;
    import fcims_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fcims_if bus ();

    fcims dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int unsigned op, input int unsigned up, input int unsigned nc,
                         input int unsigned c, input int unsigned t);
        bus.ctrl        = op[0];
        bus.uprice      = up[3:0];
        bus.ncel        = nc[3:0];
        bus.ct          = c[3:0];
        bus.tprice_init = t[7:0];
    endtask

    // Reference: plain integer arithmetic on the transaction rules.
    task automatic model(input int unsigned op, input int unsigned up, input int unsigned nc,
                         input int unsigned c, input int unsigned t,
                         output int unsigned e_fp, output int unsigned e_ct,
                         output int unsigned e_tot, output int unsigned e_err);
        int p;
        int cc;
        int tt;
        bit bad;
        p = int'(up * nc);
        if (op == 0) begin
            cc  = int'(c) + int'(nc);
            tt  = int'(t) + p;
            bad = (cc > 15) || (tt > 255);
        end else begin
            cc  = int'(c) - int'(nc);
            tt  = int'(t) - p;
            bad = (cc < 0) || (tt < 0);
        end
        e_fp  = p;
        e_ct  = bad ? c : int'(cc);
        e_tot = bad ? t : int'(tt);
        e_err = bad ? 1 : 0;
    endtask

    task automatic run_txn(input string tag, input int unsigned op, input int unsigned up,
                           input int unsigned nc, input int unsigned c, input int unsigned t);
        int unsigned e_fp, e_ct, e_tot, e_err;
        @(negedge clk);
        drive(op, up, nc, c, t);
        model(op, up, nc, c, t, e_fp, e_ct, e_tot, e_err);
        @(posedge clk);
        #1;
        $display("txn %s op=%0d up=%0d n=%0d ct=%0d tot=%0d -> fp=%0d ct=%0d tot=%0d err=%0d",
                 tag, op, up, nc, c, t, bus.fprice, bus.new_ct, bus.tprice_final, bus.err);
        check_val({tag, "_fprice"}, bus.fprice, e_fp);
        check_val({tag, "_new_ct"}, bus.new_ct, e_ct);
        check_val({tag, "_tprice"}, bus.tprice_final, e_tot);
        check_val({tag, "_err"}, bus.err, e_err);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_fprice"}, bus.fprice, 0);
        check_val({tag, "_new_ct"}, bus.new_ct, 0);
        check_val({tag, "_tprice"}, bus.tprice_final, 0);
        check_val({tag, "_err"}, bus.err, 0);
    endtask

    // Assert reset between edges, hold it across an edge, then release mid-cycle.
    task automatic async_reset_seq();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_held");
        @(negedge clk);
        drive(0, 8, 3, 0, 0);
        #2 reset = 1'b0;
        #1 check_zero("rst_release");
        $display("txn rst_sequence released with add 8x3");
        @(posedge clk);
        #1;
        check_val("rst_first_fprice", bus.fprice, 24);
        check_val("rst_first_new_ct", bus.new_ct, 3);
        check_val("rst_first_tprice", bus.tprice_final, 24);
        check_val("rst_first_err", bus.err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2 check_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        run_txn("add_empty",    0, 8, 3, 0, 0);
        run_txn("add_chain",    0, 8, 3, 3, 24);
        run_txn("remove",       1, 2, 4, 6, 48);
        run_txn("ct_underflow", 1, 1, 7, 5, 50);
        run_txn("ct_overflow",  0, 1, 10, 9, 0);
        run_txn("tot_overflow", 0, 15, 15, 0, 100);
        run_txn("ncel_zero",    1, 9, 0, 4, 77);
        run_txn("add_edge",     0, 15, 1, 15, 240);
        run_txn("rem_price",    1, 3, 2, 8, 5);
        run_txn("rem_exact",    1, 15, 15, 15, 225);

        async_reset_seq();

        for (int i = 0; i < 200; i++) begin
            int unsigned op, up, nc, c, t;
            op = $urandom_range(1, 0);
            up = $urandom_range(15, 0);
            nc = $urandom_range(15, 0);
            c  = $urandom_range(15, 0);
            t  = $urandom_range(255, 0);
            run_txn($sformatf("rnd%0d", i), op, up, nc, c, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
